fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline; it produces the instruction and next-PC pair consumed by the IF/ID latch. It owns the program counter and runs a request/ready handshake to instruction memory. It honours decode-stage stalls and branch redirects, and delivers at most one instruction per cycle with a registered valid qualifier.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_hold_buf.sv | 37 +++
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage state enum, widths and constants
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // PC arithmetic is deliberately modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - single-entry {instr, npc} buffer used while decode stalls
module fetch_hold_buf
  import mips_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [31:0]        i_npc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [31:0]        o_npc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [31:0]        r_npc;

  // Clear wins over load so a redirect always empties the buffer.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_npc   <= 32'h0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_npc   <= i_npc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_npc   = r_npc;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch stage with imem req/ready handshake
// Optional perf_fetched/perf_squashed counters when FETCH_PERF_EN is defined.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               pc_src,
  input  logic [31:0]        branch_target,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [31:0]        npc_out,
  output logic               valid_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_squashed
`endif
);

  fetch_state_e       r_state, w_state_nxt;
  logic [31:0]        r_pc, w_pc_nxt;
  logic [31:0]        r_redir_pc, w_redir_nxt;
  logic               r_req, w_req_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic [31:0]        r_npc, w_npc_nxt;
  logic               r_valid, w_valid_nxt;

  logic               w_ack;
  logic [31:0]        w_pc_inc;
  logic               w_buf_load, w_buf_clear, w_buf_valid;
  logic [INSTR_W-1:0] w_buf_instr;
  logic [31:0]        w_buf_npc;

  // A ready strobe only counts while a request is actually outstanding.
  assign w_ack    = r_req && imem_ready;
  assign w_pc_inc = next_pc(r_pc);

  fetch_hold_buf u_hold_buf (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_instr (imem_rdata),
    .i_npc   (w_pc_inc),
    .o_valid (w_buf_valid),
    .o_instr (w_buf_instr),
    .o_npc   (w_buf_npc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_redir_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_npc      <= 32'h0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_redir_pc <= w_redir_nxt;
      r_req      <= w_req_nxt;
      r_instr    <= w_instr_nxt;
      r_npc      <= w_npc_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_redir_nxt = r_redir_pc;
    w_req_nxt   = r_req;
    w_instr_nxt = r_instr;
    w_npc_nxt   = r_npc;
    w_valid_nxt = r_valid;
    w_buf_load  = 1'b0;
    w_buf_clear = 1'b0;
    if (!stall) begin
      w_instr_nxt = NOP_INSTR;
      w_valid_nxt = 1'b0;
    end
    case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
        w_req_nxt   = 1'b1;
        if (pc_src) w_pc_nxt = branch_target;
      end
      FETCH: begin
        if (pc_src) begin
          w_buf_clear = 1'b1;
          if (w_ack) begin
            w_pc_nxt = branch_target;
          end else begin
            // Old address stays on the bus until memory answers.
            w_redir_nxt = branch_target;
            w_state_nxt = DRAIN;
          end
        end else if (w_ack) begin
          w_pc_nxt = w_pc_inc;
          if (stall) begin
            w_buf_load  = 1'b1;
            w_req_nxt   = 1'b0;
            w_state_nxt = HOLD;
          end else begin
            w_instr_nxt = imem_rdata;
            w_npc_nxt   = w_pc_inc;
            w_valid_nxt = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (w_ack) begin
          w_pc_nxt    = pc_src ? branch_target : r_redir_pc;
          w_state_nxt = FETCH;
        end else if (pc_src) begin
          w_redir_nxt = branch_target;
        end
      end
      HOLD: begin
        if (pc_src) begin
          w_buf_clear = 1'b1;
          w_pc_nxt    = branch_target;
          w_req_nxt   = 1'b1;
          w_state_nxt = FETCH;
        end else if (!stall) begin
          w_instr_nxt = w_buf_instr;
          w_npc_nxt   = w_buf_npc;
          w_valid_nxt = w_buf_valid;
          w_buf_clear = 1'b1;
          w_req_nxt   = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (pc_src) begin
      w_instr_nxt = NOP_INSTR;
      w_valid_nxt = 1'b0;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign instr_out = r_instr;
  assign npc_out   = r_npc;
  assign valid_out = r_valid;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_squashed;
  logic        w_fetched, w_squashed;

  assign w_fetched  = !pc_src && !stall &&
                      ((r_state == FETCH && w_ack) || (r_state == HOLD && w_buf_valid));
  assign w_squashed = w_ack && (r_state == DRAIN || (r_state == FETCH && pc_src));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched  <= 32'h0;
      r_perf_squashed <= 32'h0;
    end else begin
      if (w_fetched)  r_perf_fetched  <= r_perf_fetched + 32'd1;
      if (w_squashed) r_perf_squashed <= r_perf_squashed + 32'd1;
    end
  end

  assign perf_fetched  = r_perf_fetched;
  assign perf_squashed = r_perf_squashed;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a wait-state memory model
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst, stall, pc_src, imem_ready;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, valid_out;
  logic [31:0] imem_addr, instr_out, npc_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_squashed;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_out     (instr_out),
    .npc_out       (npc_out),
    .valid_out     (valid_out)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_squashed (perf_squashed)
`endif
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wait_n  = 0;
  int          wait_cnt = 0;
  logic        noise_en = 1'b0;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] m_instr = 32'h0, m_npc = 32'h0;
  logic        m_valid = 1'b0;
  int          m_deliv = 0;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1;
  logic [31:0] prev_addr = 32'h0, last_addr = 32'h0;

  // Memory contents: a nonzero word that encodes its own address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, answer the memory request, then score the outputs.
  task automatic step(input logic s, input logic p, input logic [31:0] tgt);
    logic        req_now, ack;
    logic [31:0] addr_now;
    stall = s;
    pc_src = p;
    branch_target = tgt;
    req_now = imem_req;
    addr_now = imem_addr;
    ack = 1'b0;
    if (req_now === 1'b1 && !rst) begin
      ack = (wait_cnt >= wait_n);
      imem_ready = ack;
      imem_rdata = ack ? word_of(addr_now) : $urandom;
    end else begin
      imem_ready = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = $urandom;
    end
    last_addr = addr_now;
    if (prev_req && !prev_ack && !prev_rst) begin
      check("req_stable", {31'h0, req_now}, 32'h1);
      check("addr_stable", addr_now, prev_addr);
    end
    @(posedge clk);
    #1;
    if (req_now === 1'b1 && !rst) wait_cnt = ack ? 0 : wait_cnt + 1;
    else wait_cnt = 0;
    if (rst) begin
      exp_pc = RST_PC; m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0; m_deliv = 0;
      check("valid", {31'h0, valid_out}, {31'h0, m_valid});
    end else if (p) begin
      exp_pc = tgt; m_valid = 1'b0; m_instr = 32'h0;
      check("valid", {31'h0, valid_out}, {31'h0, m_valid});
    end else if (!s && valid_out === 1'b1) begin
      m_instr = word_of(exp_pc); m_npc = exp_pc + 32'd4; m_valid = 1'b1;
      exp_pc = exp_pc + 32'd4; m_deliv++;
    end else begin
      if (!s) begin m_valid = 1'b0; m_instr = 32'h0; end
      check("valid", {31'h0, valid_out}, {31'h0, m_valid});
    end
    check("instr", instr_out, m_instr);
    check("npc", npc_out, m_npc);
    prev_req = (req_now === 1'b1);
    prev_ack = ack;
    prev_addr = addr_now;
    prev_rst = rst;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; stall = 1'b0; pc_src = 1'b0; branch_target = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;

    step(0, 0, 0);
    step(0, 0, 0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_valid", {31'h0, valid_out}, 32'h0);

    rst = 1'b0;
    step(0, 0, 0);
    check("first_req", {31'h0, imem_req}, 32'h1);
    check("first_addr", imem_addr, RST_PC);
    check("first_bubble", {31'h0, valid_out}, 32'h0);
    step(0, 0, 0);
    check("first_valid", {31'h0, valid_out}, 32'h1);
    check("first_npc", npc_out, RST_PC + 32'h4);
    check("first_instr", instr_out, word_of(RST_PC));
    for (int k = 1; k < 4; k++) begin
      step(0, 0, 0);
      check("stream_valid", {31'h0, valid_out}, 32'h1);
      check("stream_npc", npc_out, RST_PC + 32'(4 * (k + 1)));
    end

    wait_n = 3;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0);
      check("ws_addr", last_addr, RST_PC + 32'h10);
      if (k < 3) begin
        check("ws_bubble_valid", {31'h0, valid_out}, 32'h0);
        check("ws_bubble_instr", instr_out, 32'h0);
      end else begin
        check("ws_valid", {31'h0, valid_out}, 32'h1);
        check("ws_npc", npc_out, RST_PC + 32'h14);
      end
    end

    wait_n = 0;
    noise_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0);
      check("hold_req", {31'h0, imem_req}, 32'h0);
      check("hold_npc", npc_out, RST_PC + 32'h14);
      check("hold_valid", {31'h0, valid_out}, 32'h1);
    end
    step(0, 0, 0);
    check("unhold_valid", {31'h0, valid_out}, 32'h1);
    check("unhold_npc", npc_out, RST_PC + 32'h18);
    check("unhold_instr", instr_out, word_of(RST_PC + 32'h14));
    check("unhold_req", {31'h0, imem_req}, 32'h1);

    wait_n = 2;
    step(0, 1, 32'h0000_0100);
    check("drain_valid", {31'h0, valid_out}, 32'h0);
    check("drain_addr", imem_addr, RST_PC + 32'h18);
    step(0, 0, 0);
    step(0, 0, 0);
    check("drain_drop_valid", {31'h0, valid_out}, 32'h0);
    check("redir_addr", imem_addr, 32'h0000_0100);
    check("redir_req", {31'h0, imem_req}, 32'h1);
`ifdef FETCH_PERF_EN
    check("perf_squashed", perf_squashed, 32'h1);
`endif
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("redir_first_valid", {31'h0, valid_out}, 32'h1);
    check("redir_first_npc", npc_out, 32'h0000_0104);

    wait_n = 0;
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 32'h0000_0200);
    check("holdredir_valid", {31'h0, valid_out}, 32'h0);
    check("holdredir_instr", instr_out, 32'h0);
    check("holdredir_req", {31'h0, imem_req}, 32'h1);
    check("holdredir_addr", imem_addr, 32'h0000_0200);
    step(0, 0, 0);
    check("holdredir_npc", npc_out, 32'h0000_0204);
    check("holdredir_instr2", instr_out, word_of(32'h0000_0200));

    step(0, 1, 32'hFFFF_FFF8);
    step(0, 0, 0);
    check("wrap_npc0", npc_out, 32'hFFFF_FFFC);
    step(0, 0, 0);
    check("wrap_npc1", npc_out, 32'h0000_0000);
    step(0, 0, 0);
    check("wrap_npc2", npc_out, 32'h0000_0004);
    step(0, 1, 32'h0000_0303);
    step(0, 0, 0);
    check("unaligned_npc", npc_out, 32'h0000_0307);
    check("unaligned_instr", instr_out, word_of(32'h0000_0303));

    wait_n = 3;
    step(0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0);
    check("midrst_req", {31'h0, imem_req}, 32'h0);
    rst = 1'b0;
    wait_n = 0;
    step(0, 0, 0);
    check("midrst_addr", imem_addr, RST_PC);
    step(0, 0, 0);
    check("midrst_npc", npc_out, RST_PC + 32'h4);

    for (int k = 0; k < 400; k++) begin
      wait_n = $urandom_range(0, 2);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom);
    end

    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(0, 0, 0);
      seen = (valid_out === 1'b1);
    end
    check("liveness", {31'h0, seen}, 32'h1);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'(m_deliv));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
